router_pkt_tx: RTL and testbench

Packet transmitter that drives the input side of the 1x3 router (`datain`, `packet_valid`, honouring `busy`, observing `err`). It accepts a command (destination, length) and a payload byte stream from local logic, buffers the complete payload, then emits a header byte, the payload bytes and a parity byte. It then reports a per-packet completion flag together with the router's parity-error verdict. It sits between a test or host source and the router top.

---
 rtl/router_pkg.sv | 35 +++
 rtl/router_tx_buf.sv | 41 ++++
 rtl/router_pkt_tx.sv | 174 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet path: header field layout, default sizes
// and the transmitter state encoding.
package router_pkg;

  // Header byte layout: {len[5:0], addr[1:0]}
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_MSB  = 7;

  localparam int unsigned MAX_LEN_DEF  = 63;
  localparam int unsigned ERR_WAIT_DEF = 3;

  localparam int unsigned BUF_DEPTH = 64;
  localparam int unsigned PTR_W     = 6;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StHdr  = 3'd2,
    StPay  = 3'd3,
    StPar  = 3'd4,
    StChk  = 3'd5,
    StDone = 3'd6
  } tx_state_e;

  function automatic logic [7:0] make_hdr(input logic [1:0] addr, input logic [5:0] len);
    logic [7:0] hdr;
    hdr = '0;
    hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: 64x8 register array, write pointer advanced while loading,
// read pointer advanced while transmitting; both pointers cleared at packet start.
module router_tx_buf
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_adv,
  output logic [7:0]       rd_data,
  output logic [PTR_W-1:0] rd_ptr
);

  logic [7:0]       mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 6'd1;
      if (rd_adv) rd_ptr_q <= rd_ptr_q + 6'd1;
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign rd_ptr  = rd_ptr_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header, payload and parity,
// and reports the router's parity verdict. ROUTER_TX_PAR_INJ_EN adds the inj_par port.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned MAX_LEN  = MAX_LEN_DEF,
  parameter int unsigned ERR_WAIT = ERR_WAIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
`ifdef ROUTER_TX_PAR_INJ_EN
  input  logic       inj_par,
`endif
  output logic       cmd_rej,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic [7:0] datain,
  output logic       packet_valid,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_done,
  output logic       pkt_err
);

  localparam logic [5:0] MaxLen  = 6'(MAX_LEN);
  localparam logic [5:0] ErrLast = 6'(ERR_WAIT - 1);

  tx_state_e  state_q;
  logic [7:0] hdr_q;
  logic [5:0] len_q;
  logic [7:0] par_q;
  logic [5:0] cnt_q;
  logic       err_acc_q;

  logic             cmd_legal;
  logic             buf_clr;
  logic             buf_wr;
  logic             buf_rd_adv;
  logic [7:0]       buf_rd_data;
  logic [PTR_W-1:0] buf_rd_ptr;
  logic             pay_last;
  logic [7:0]       par_tx;

  assign cmd_ready = (state_q == StIdle);
  assign pl_ready  = (state_q == StLoad);

  assign cmd_legal = (cmd_addr != 2'd3) && (cmd_len != 6'd0) && (cmd_len <= MaxLen);
  assign buf_clr   = cmd_ready && cmd_valid && cmd_legal;
  assign buf_wr    = pl_ready && pl_valid;

  // Read pointer runs one ahead of the byte on datain, so reaching len means the
  // last payload byte is currently being presented.
  assign pay_last   = (buf_rd_ptr == len_q);
  assign buf_rd_adv = !busy && ((state_q == StHdr) || ((state_q == StPay) && !pay_last));

`ifdef ROUTER_TX_PAR_INJ_EN
  logic inj_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else if (buf_clr) begin
      inj_q <= inj_par;
    end
  end

  assign par_tx = par_q ^ {7'b0, inj_q};
`else
  assign par_tx = par_q;
`endif

  router_tx_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (pl_data),
    .rd_adv  (buf_rd_adv),
    .rd_data (buf_rd_data),
    .rd_ptr  (buf_rd_ptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hdr_q        <= '0;
      len_q        <= '0;
      par_q        <= '0;
      cnt_q        <= '0;
      err_acc_q    <= 1'b0;
      datain       <= '0;
      packet_valid <= 1'b0;
      cmd_rej      <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      cmd_rej  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_legal) begin
              hdr_q   <= make_hdr(cmd_addr, cmd_len);
              par_q   <= make_hdr(cmd_addr, cmd_len);
              len_q   <= cmd_len;
              cnt_q   <= '0;
              state_q <= StLoad;
            end else begin
              cmd_rej <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (pl_valid) begin
            par_q <= par_q ^ pl_data;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == len_q - 6'd1) begin
              state_q      <= StHdr;
              datain       <= hdr_q;
              packet_valid <= 1'b1;
            end
          end
        end
        StHdr: begin
          if (!busy) begin
            state_q <= StPay;
            datain  <= buf_rd_data;
          end
        end
        StPay: begin
          if (!busy) begin
            if (pay_last) begin
              state_q      <= StPar;
              datain       <= par_tx;
              packet_valid <= 1'b0;
            end else begin
              datain <= buf_rd_data;
            end
          end
        end
        StPar: begin
          if (!busy) begin
            state_q   <= StChk;
            datain    <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
          end
        end
        StChk: begin
          err_acc_q <= err_acc_q | err;
          cnt_q     <= cnt_q + 6'd1;
          if (cnt_q == ErrLast) begin
            state_q  <= StDone;
            pkt_done <= 1'b1;
            pkt_err  <= err_acc_q | err;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed table-driven bench for router_pkt_tx plus hand sequences for reset and
// parity injection (the latter only when ROUTER_TX_PAR_INJ_EN is defined).
module tb_router_pkt_tx;

  localparam int ERR_WAIT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
`ifdef ROUTER_TX_PAR_INJ_EN
  logic       inj_par;
`endif
  logic       cmd_rej;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic [7:0] datain;
  logic       packet_valid;
  logic       busy;
  logic       err;
  logic       pkt_done;
  logic       pkt_err;

  int n_pass = 0;
  int n_tot  = 0;

  router_pkt_tx dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
`ifdef ROUTER_TX_PAR_INJ_EN
    .inj_par      (inj_par),
`endif
    .cmd_rej      (cmd_rej),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .datain       (datain),
    .packet_valid (packet_valid),
    .busy         (busy),
    .err          (err),
    .pkt_done     (pkt_done),
    .pkt_err      (pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    logic [7:0] seed;   // payload byte i = seed + i*step
    logic [7:0] step;
    int         stall_k; // output slot held busy (0=hdr, len+1=parity), -1 none
    int         stall_n;
    logic       noise;   // busy/err high while loading
    int         err_at;  // cycles after parity byte that err is high, -1 none
    logic       inj;
    logic       rej;
    logic [7:0] hdr;
    logic [7:0] par;
    logic       perr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pkt(input vec_t v);
    int         len;
    int         k;
    int         obs;
    int         stall_left;
    int         cyc;
    logic       done;
    logic [7:0] exp_b;
    len = int'(v.len);
    tick();
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
`ifdef ROUTER_TX_PAR_INJ_EN
    inj_par   = v.inj;
`endif
    tick();
    cmd_valid = 1'b0;
    if (v.rej) begin
      chk("cmd_rej_pulse", 32'(cmd_rej), 32'd1);
      chk("rej_pv_low", 32'(packet_valid), 32'd0);
      chk("rej_stays_idle", 32'(cmd_ready), 32'd1);
      tick();
      chk("cmd_rej_one_cycle", 32'(cmd_rej), 32'd0);
      chk("rej_pv_low2", 32'(packet_valid), 32'd0);
      return;
    end
    chk("cmd_rej_quiet", 32'(cmd_rej), 32'd0);
    chk("cmd_ready_load", 32'(cmd_ready), 32'd0);
    chk("pl_ready_load", 32'(pl_ready), 32'd1);
    for (int i = 0; i < len; i++) begin
      pl_valid = 1'b1;
      pl_data  = v.seed + 8'(i) * v.step;
      busy     = v.noise;
      err      = v.noise;
      tick();
    end
    pl_valid = 1'b0;
    busy     = 1'b0;
    err      = 1'b0;
    chk("hdr_latency", 32'(datain), 32'(v.hdr));
    chk("pl_ready_off", 32'(pl_ready), 32'd0);

    k = 0;
    obs = 0;
    stall_left = v.stall_n;
    for (int c = 0; c < 200 && k <= len + 1; c++) begin
      if (k == 0) exp_b = v.hdr;
      else if (k <= len) exp_b = v.seed + 8'(k - 1) * v.step;
      else exp_b = v.par;
      chk("out_byte", 32'(datain), 32'(exp_b));
      chk("out_pv", 32'(packet_valid), (k <= len) ? 32'd1 : 32'd0);
      obs++;
      if (k == v.stall_k && stall_left > 0) begin
        busy = 1'b1;
        stall_left--;
      end else begin
        busy = 1'b0;
        k++;
      end
      tick();
    end
    busy = 1'b0;
    chk("out_cycles", 32'(obs), 32'(len + 2 + v.stall_n));

    cyc = 1;
    done = 1'b0;
    while (!done && cyc <= 20) begin
      if (pkt_done) begin
        chk("pkt_err", 32'(pkt_err), 32'(v.perr));
        chk("done_latency", 32'(cyc), 32'(ERR_WAIT + 1));
        err  = 1'b0;
        done = 1'b1;
      end else begin
        chk("chk_datain_zero", 32'(datain), 32'd0);
        chk("chk_pv_low", 32'(packet_valid), 32'd0);
        err = (cyc == v.err_at);
        cyc++;
      end
      tick();
    end
    err = 1'b0;
    chk("pkt_done_seen", 32'(done), 32'd1);
    chk("pkt_done_pulse", 32'(pkt_done), 32'd0);
    chk("idle_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //           addr  len    seed   step  stk sn noise err inj  rej  hdr    par    perr
    vecs.push_back('{2'd1, 6'd3, 8'h11, 8'h11, -1, 0, 1'b0, -1, 1'b0, 1'b0, 8'h0D, 8'h0D, 1'b0});
    vecs.push_back('{2'd1, 6'd3, 8'h11, 8'h11, 2, 2, 1'b0, -1, 1'b0, 1'b0, 8'h0D, 8'h0D, 1'b0});
    vecs.push_back('{2'd0, 6'd1, 8'hA5, 8'h00, -1, 0, 1'b1, -1, 1'b0, 1'b0, 8'h04, 8'hA1, 1'b0});
    vecs.push_back('{2'd2, 6'd2, 8'hF0, 8'h01, 0, 1, 1'b0, 1, 1'b0, 1'b0, 8'h0A, 8'h0B, 1'b1});
    vecs.push_back('{2'd3, 6'd3, 8'h00, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{2'd1, 6'd0, 8'h00, 8'h00, -1, 0, 1'b0, -1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
    vecs.push_back('{2'd2, 6'd63, 8'h00, 8'h01, -1, 0, 1'b0, -1, 1'b0, 1'b0, 8'hFE, 8'hC1, 1'b0});
    vecs.push_back('{2'd0, 6'd4, 8'h80, 8'h00, 5, 3, 1'b0, -1, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0});

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
`ifdef ROUTER_TX_PAR_INJ_EN
    inj_par   = 1'b0;
`endif
    pl_valid  = 1'b0;
    pl_data   = '0;
    busy      = 1'b0;
    err       = 1'b0;
    #1;
    chk("rst_datain", 32'(datain), 32'd0);
    chk("rst_pv", 32'(packet_valid), 32'd0);
    chk("rst_cmd_rej", 32'(cmd_rej), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_err", 32'(pkt_err), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    foreach (vecs[i]) run_pkt(vecs[i]);

    // Reset while the first payload byte is on the wire.
    tick();
    cmd_valid = 1'b1;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd4;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pl_valid = 1'b1;
      pl_data  = 8'h55 + 8'(i);
      tick();
    end
    pl_valid = 1'b0;
    chk("mid_rst_hdr", 32'(datain), 32'h10);
    tick();
    chk("mid_rst_pay0", 32'(datain), 32'h55);
    chk("mid_rst_pv_before", 32'(packet_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pv_async", 32'(packet_valid), 32'd0);
    chk("mid_rst_datain", 32'(datain), 32'd0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (pkt_done) seen++;
      tick();
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    chk("mid_rst_idle", 32'(cmd_ready), 32'd1);
    run_pkt(vecs[0]);

`ifdef ROUTER_TX_PAR_INJ_EN
    run_pkt('{2'd1, 6'd3, 8'h11, 8'h11, -1, 0, 1'b0, 2, 1'b1, 1'b0, 8'h0D, 8'h0C, 1'b1});
    inj_par = 1'b0;
    run_pkt(vecs[0]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
